// File: rtl/kbd_ring_writer.sv
// kbd_ring_writer
// Buffers ASCII bytes from the PS/2 decoder in a small local FIFO and drains
// them into a memory-mapped ring buffer through data-memory port B. The block
// owns the ring head word (BUF_BASE+0). Software owns the tail word
// (BUF_BASE+4). Entries live at BUF_BASE+8+4*i.
//
// Ports
//   clk         memory clock (same as data-memory port B)
//   rst         synchronous reset, active high
//   key_valid   one-cycle strobe, key_data holds a new ASCII byte
//   key_data    ASCII byte
//   io_addr     port-B byte address (registered)
//   io_wren     port-B write enable (registered)
//   io_wdata    port-B write data (registered)
//   io_rdata    port-B read data, valid the cycle after the address
//   busy        FSM not in IDLE (registered)
//   fifo_level  bytes currently held in the local FIFO
//   drop_count  bytes lost to FIFO overflow, saturating at 255
module kbd_ring_writer #(
    parameter logic [31:0] BUF_BASE   = 32'h0000_1000,
    parameter int          BUF_DEPTH  = 64,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [7:0]                    key_data,
    output logic [31:0]                   io_addr,
    output logic                          io_wren,
    output logic [31:0]                   io_wdata,
    input  logic [31:0]                   io_rdata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);

    localparam int          IW       = $clog2(BUF_DEPTH);
    localparam int          FW       = $clog2(FIFO_DEPTH);
    localparam int          LW       = FW + 1;
    localparam logic [31:0] IDX_MASK = 32'(BUF_DEPTH - 1);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        RD_TAIL = 3'd2,
        RD_WAIT = 3'd3,
        WR_DATA = 3'd4,
        WR_HEAD = 3'd5
    } state_t;

    state_t         state_r, next_state_s;
    logic [IW-1:0]  head_r;
    logic [IW-1:0]  head_inc_s;
    logic [7:0]     fifo_mem_r [FIFO_DEPTH];
    logic [FW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic [7:0]     drop_r;
    logic [31:0]    io_addr_r, io_wdata_r;
    logic [31:0]    addr_s, wdata_s;
    logic           io_wren_r, wren_s;
    logic           busy_r;
    logic           rst_seen_r;
    logic           push_s, pop_s, head_upd_s, ring_full_s;

    assign head_inc_s = head_r + 1'b1;  // IW-bit add wraps modulo BUF_DEPTH
    // Level is sampled at cycle start, so a same-cycle pop cannot make room.
    assign push_s     = key_valid && (level_r < LW'(FIFO_DEPTH));
    // Tail compare uses the whole read word, masked to index bits.
    assign ring_full_s = ({{(32-IW){1'b0}}, head_inc_s} == (io_rdata & IDX_MASK));

    // Next-state and next-output decode; outputs are registered for the state being entered.
    always_comb begin
        next_state_s = state_r;
        addr_s       = io_addr_r;
        wdata_s      = io_wdata_r;
        wren_s       = 1'b0;
        pop_s        = 1'b0;
        head_upd_s   = 1'b0;
        case (state_r)
            INIT: begin
                // Leave only once the head-clear write has actually been on the bus.
                if (io_wren_r) begin
                    next_state_s = IDLE;
                end else begin
                    addr_s  = BUF_BASE;
                    wdata_s = 32'd0;
                    wren_s  = 1'b1;
                end
            end
            IDLE: begin
                if (level_r != '0) begin
                    next_state_s = RD_TAIL;
                    addr_s       = BUF_BASE + 32'd4;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_TAIL: begin
                next_state_s = RD_WAIT;
            end
            RD_WAIT: begin
                if (ring_full_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WR_DATA;
                    addr_s       = BUF_BASE + 32'd8 + {{(30-IW){1'b0}}, head_r, 2'b00};
                    wdata_s      = {24'd0, fifo_mem_r[rd_ptr_r]};
                    wren_s       = 1'b1;
                end
            end
            WR_DATA: begin
                pop_s        = 1'b1;
                next_state_s = WR_HEAD;
                addr_s       = BUF_BASE;
                wdata_s      = {{(32-IW){1'b0}}, head_inc_s};
                wren_s       = 1'b1;
            end
            WR_HEAD: begin
                head_upd_s   = 1'b1;
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = INIT;
            end
        endcase
    end

    // FSM, head index, port-B output registers and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= INIT;
            head_r     <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            drop_r     <= 8'd0;
            io_addr_r  <= BUF_BASE;
            io_wdata_r <= 32'd0;
            // First reset cycle keeps the bus quiet; a held reset presents the INIT write.
            io_wren_r  <= rst_seen_r;
            busy_r     <= 1'b1;
            rst_seen_r <= 1'b1;
        end else begin
            rst_seen_r <= 1'b0;
            state_r    <= next_state_s;
            io_addr_r  <= addr_s;
            io_wdata_r <= wdata_s;
            io_wren_r  <= wren_s;
            busy_r     <= (next_state_s != IDLE);
            if (head_upd_s) begin
                head_r <= head_inc_s;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
            if (key_valid && !push_s && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_mem_r[wr_ptr_r] <= key_data;
        end
    end

    assign io_addr    = io_addr_r;
    assign io_wren    = io_wren_r;
    assign io_wdata   = io_wdata_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;
    assign drop_count = drop_r;

endmodule

// File: tb/tb_kbd_ring_writer.sv
// Testbench for kbd_ring_writer: behaves as data memory plus the consuming
// software (owns the tail word) and checks ring writes against a byte-queue
// model of what the ring must contain.
module tb_kbd_ring_writer;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_data;
    logic [31:0] io_addr;
    logic        io_wren;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        busy;
    logic [3:0]  fifo_level;
    logic [7:0]  drop_count;

    kbd_ring_writer dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .io_addr    (io_addr),
        .io_wren    (io_wren),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .busy       (busy),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Memory model and write log
    logic [31:0] mem [0:4095];
    logic [31:0] tail_val;
    int          cyc = 0;
    logic [31:0] wl_addr [$];
    logic [31:0] wl_data [$];
    int          wl_cyc  [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (io_wren) begin
            mem[io_addr[13:2]] <= io_wdata;
            wl_addr.push_back(io_addr);
            wl_data.push_back(io_wdata);
            wl_cyc.push_back(cyc);
        end
        io_rdata <= (io_addr == BASE + 32'd4) ? tail_val : mem[io_addr[13:2]];
    end

    // Reference model state
    logic [7:0] exp_q [$];
    int         exp_head;
    int         exp_drop;
    int         total = 0;
    int         bad   = 0;
    int         last_head_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        key_valid = 1'b1;
        key_data  = b;
        step();
        key_valid = 1'b0;
    endtask

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
        wl_cyc.delete();
    endtask

    // Wait for the DUT to be inside WR_DATA (entry write on the bus).
    task automatic wait_wr_data();
        int w = 0;
        while (!(io_wren === 1'b1 && io_addr !== BASE) && w < 100) begin
            step();
            w++;
        end
        if (w >= 100) chk("wr_data_timeout", 32'(w), 32'd0);
    endtask

    // Each accepted byte must appear as an entry write followed next cycle by a head write.
    task automatic drain_check(input int n);
        for (int i = 0; i < n; i++) begin
            int         w = 0;
            logic [7:0] b;
            while (wl_addr.size() < 2 && w < 400) begin
                step();
                w++;
            end
            if (wl_addr.size() < 2) begin
                chk("drain_timeout", 32'(wl_addr.size()), 32'd2);
                return;
            end
            b = exp_q.pop_front();
            chk("entry_addr", wl_addr[0], BASE + 32'd8 + 32'(4 * exp_head));
            chk("entry_data", wl_data[0], {24'd0, b});
            exp_head = (exp_head + 1) % DEPTH;
            chk("head_addr", wl_addr[1], BASE);
            chk("head_data", wl_data[1], 32'(exp_head));
            chk("head_follows_entry", 32'(wl_cyc[1] - wl_cyc[0]), 32'd1);
            last_head_cyc = wl_cyc[1];
            void'(wl_addr.pop_front()); void'(wl_addr.pop_front());
            void'(wl_data.pop_front()); void'(wl_data.pop_front());
            void'(wl_cyc.pop_front());  void'(wl_cyc.pop_front());
        end
    endtask

    initial begin
        int         p;
        logic [7:0] b;

        rst = 1'b1; key_valid = 1'b0; key_data = 8'd0; tail_val = 32'd0;
        exp_head = 0; exp_drop = 0;

        // 1: reset held two cycles, then INIT write, then IDLE
        step(); step();
        rst = 1'b0;
        chk("init_wren", {31'd0, io_wren}, 32'd1);
        chk("init_addr", io_addr, BASE);
        chk("init_wdata", io_wdata, 32'd0);
        chk("init_busy", {31'd0, busy}, 32'd1);
        chk("init_level", {28'd0, fifo_level}, 32'd0);
        chk("init_drop", {24'd0, drop_count}, 32'd0);
        step();
        chk("idle_wren", {31'd0, io_wren}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("head_word_cleared", mem[BASE[13:2]], 32'd0);
        clear_log();

        // 2: single key, check addresses and latency
        p = cyc;
        send(8'h41); exp_q.push_back(8'h41);
        chk("level_after_push", {28'd0, fifo_level}, 32'd1);
        drain_check(1);
        chk("latency", 32'(last_head_cyc - p), 32'd5);
        chk("level_drained", {28'd0, fifo_level}, 32'd0);

        // 4: ring full, ten back-to-back keys, two dropped, then drain in order
        tail_val = 32'((exp_head + 1) % DEPTH);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if (i < 8) exp_q.push_back(b);
            else exp_drop++;
            key_valid = 1'b1;
            key_data  = b;
            step();
        end
        key_valid = 1'b0;
        repeat (10) step();
        chk("full_level", {28'd0, fifo_level}, 32'd8);
        chk("full_drop", {24'd0, drop_count}, 32'(exp_drop));
        chk("full_no_write", 32'(wl_addr.size()), 32'd0);
        tail_val = 32'(exp_head);
        drain_check(8);

        // 5: push attempt during WR_DATA with FIFO full is rejected
        tail_val = 32'((exp_head + 1) % DEPTH);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send(b);
        end
        repeat (6) step();
        chk("fill_level", {28'd0, fifo_level}, 32'd8);
        tail_val = 32'(exp_head);
        wait_wr_data();
        send(8'hEE); exp_drop++;
        chk("pop_push_level", {28'd0, fifo_level}, 32'd7);
        chk("pop_push_drop", {24'd0, drop_count}, 32'(exp_drop));
        drain_check(8);

        // random spaced traffic to bring head up to the wrap point
        tail_val = 32'(exp_head);
        while (exp_head + exp_q.size() < DEPTH - 1) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send(b);
            repeat ($urandom_range(4, 7)) step();
        end
        drain_check(exp_q.size());
        chk("head_at_top", 32'(exp_head), 32'(DEPTH - 1));
        chk("rand_drop", {24'd0, drop_count}, 32'(exp_drop));

        // 3: head=63 with tail=0 is full; freeing one slot lets the write wrap
        tail_val = 32'd0;
        send(8'h41); exp_q.push_back(8'h41);
        repeat (30) step();
        chk("wrap_full_no_write", 32'(wl_addr.size()), 32'd0);
        chk("wrap_full_level", {28'd0, fifo_level}, 32'd1);
        tail_val = 32'd1;
        drain_check(1);
        chk("wrap_head_word", mem[BASE[13:2]], 32'd0);

        // 6: reset during WR_DATA, no head write, INIT clears head
        tail_val = 32'd0;
        send(8'h5A);
        wait_wr_data();
        clear_log();
        rst = 1'b1;
        step();
        chk("rst1_wren", {31'd0, io_wren}, 32'd0);
        chk("rst1_busy", {31'd0, busy}, 32'd1);
        step();
        rst = 1'b0;
        chk("rst_init_wren", {31'd0, io_wren}, 32'd1);
        chk("rst_init_addr", io_addr, BASE);
        chk("rst_level", {28'd0, fifo_level}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        step();
        chk("rst_log_size", 32'(wl_addr.size()), 32'd2);
        if (wl_addr.size() == 2) begin
            chk("rst_entry_addr", wl_addr[0], BASE + 32'd8);
            chk("rst_init_write_addr", wl_addr[1], BASE);
            chk("rst_init_write_data", wl_data[1], 32'd0);
        end
        chk("rst_head_word", mem[BASE[13:2]], 32'd0);
        exp_head = 0; exp_drop = 0; exp_q.delete();
        clear_log();
        send(8'h33); exp_q.push_back(8'h33);
        drain_check(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
